// File: rtl/ris_pkg.sv
// Shared definitions for the RIS codebook sweep sequencer: FSM state
// encoding, result-word layout and RIS element geometry.
package ris_pkg;

  typedef enum logic [2:0] {
    RIS_IDLE    = 3'd0,
    RIS_APPLY   = 3'd1,
    RIS_SETTLE  = 3'd2,
    RIS_MEASURE = 3'd3,
    RIS_NEXT    = 3'd4,
    RIS_BEST    = 3'd5,
    RIS_REPORT  = 3'd6
  } ris_state_e;

  // Result word sent when a sweep is requested on an empty codebook
  localparam logic [31:0] RIS_TX_EMPTY = 32'hFFFF_FFFF;

  // Result word layout: [31:24] best index, [23:16] zero, [15:0] best SNR
  localparam int unsigned RIS_TX_IDX_LSB = 24;
  localparam int unsigned RIS_TX_IDX_W   = 8;
  localparam int unsigned RIS_TX_SNR_LSB = 0;
  localparam int unsigned RIS_TX_SNR_W   = 16;

  // Configuration word geometry: 2 bits per element, element 1 in [1:0]
  localparam int unsigned RIS_ELEM_BITS = 2;
  localparam int unsigned RIS_ELEMS     = 16;

  function automatic logic [31:0] ris_pack_result(input logic [7:0]  idx,
                                                  input logic [15:0] snr);
    logic [31:0] r;
    r = '0;
    r[RIS_TX_IDX_LSB +: RIS_TX_IDX_W] = idx;
    r[RIS_TX_SNR_LSB +: RIS_TX_SNR_W] = snr;
    return r;
  endfunction

endpackage

// File: rtl/ris_codebook_ram.sv
// Codebook storage: DEPTH x 32-bit register file, one synchronous write
// port (load path) and one combinational read port (sweep FSM).
module ris_codebook_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port: contents are not reset, entry_count defines validity
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ris_sweep_sequencer.sv
// RIS codebook sweep controller: loads phase words, applies each in turn,
// waits a settle time, collects one SNR sample per entry, re-applies the
// best entry and emits a result word for the UART transmitter.
// Optional feature macro: RIS_SWEEP_TIMEOUT_EN (measurement timeout).
module ris_sweep_sequencer
  import ris_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned SETTLE_W       = 16,
  parameter int unsigned SNR_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_valid,
  input  logic [31:0]            load_data,
  input  logic                   load_clear,
  input  logic                   sweep_start,
  input  logic [SETTLE_W-1:0]    settle_cycles,
  input  logic                   snr_valid,
  input  logic [SNR_W-1:0]       snr_data,
  output logic [31:0]            cfg_word,
  output logic                   cfg_apply,
  output logic                   meas_req,
  output logic                   tx_start,
  output logic [31:0]            tx_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] entry_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two in 2..256");
  end
  if (SNR_W < 1 || SNR_W > 16) begin : g_bad_snr_w
    $error("SNR_W must be 1..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  ris_state_e          state;
  logic [AW-1:0]       idx;
  logic [AW-1:0]       best_idx;
  logic [SNR_W-1:0]    best_snr;
  logic [SETTLE_W-1:0] settle_lat;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                full;
  logic                we;
  logic                last;
  logic                to_hit;
  logic [AW-1:0]       raddr;
  logic [31:0]         rdata;

  assign full  = (entry_count == CW'(DEPTH));
  assign we    = (state == RIS_IDLE) && load_valid && !load_clear && !full;
  assign last  = (({1'b0, idx} + 1'b1) == entry_count);
  assign raddr = (state == RIS_BEST) ? best_idx : idx;
  assign busy  = (state != RIS_IDLE);

  ris_codebook_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_codebook (
    .clk   (clk),
    .we    (we),
    .waddr (entry_count[AW-1:0]),
    .wdata (load_data),
    .raddr (raddr),
    .rdata (rdata)
  );

`ifdef RIS_SWEEP_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Measurement timeout: counts cycles spent in MEASURE, restarts elsewhere
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    to_cnt <= '0;
    else if (state != RIS_MEASURE) to_cnt <= '0;
    else                           to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  // Sweep FSM, load bookkeeping and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RIS_IDLE;
      idx         <= '0;
      best_idx    <= '0;
      best_snr    <= '0;
      settle_lat  <= '0;
      settle_cnt  <= '0;
      entry_count <= '0;
      cfg_word    <= '0;
      cfg_apply   <= 1'b0;
      meas_req    <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
    end else begin
      cfg_apply <= 1'b0;
      tx_start  <= 1'b0;
      case (state)
        RIS_IDLE: begin
          if (load_clear)  entry_count <= '0;
          else if (we)     entry_count <= entry_count + 1'b1;
          if (sweep_start) begin
            if (entry_count != '0) begin
              state      <= RIS_APPLY;
              idx        <= '0;
              best_idx   <= '0;
              best_snr   <= '0;
              settle_lat <= settle_cycles;
            end else begin
              state <= RIS_REPORT;
            end
          end
        end
        RIS_APPLY: begin
          cfg_word   <= rdata;
          cfg_apply  <= 1'b1;
          settle_cnt <= '0;
          state      <= RIS_SETTLE;
        end
        RIS_SETTLE: begin
          if (settle_cnt == settle_lat) begin
            meas_req <= 1'b1;
            state    <= RIS_MEASURE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        RIS_MEASURE: begin
          if (snr_valid) begin
            if (snr_data > best_snr) begin
              best_snr <= snr_data;
              best_idx <= idx;
            end
            meas_req <= 1'b0;
            state    <= RIS_NEXT;
          end else if (to_hit) begin
            meas_req <= 1'b0;
            state    <= RIS_NEXT;
          end
        end
        RIS_NEXT: begin
          if (last) begin
            state <= RIS_BEST;
          end else begin
            idx   <= idx + 1'b1;
            state <= RIS_APPLY;
          end
        end
        RIS_BEST: begin
          cfg_word  <= rdata;
          cfg_apply <= 1'b1;
          state     <= RIS_REPORT;
        end
        RIS_REPORT: begin
          tx_start <= 1'b1;
          tx_data  <= (entry_count == '0) ? RIS_TX_EMPTY
                    : ris_pack_result(8'(best_idx), 16'(best_snr));
          state    <= RIS_IDLE;
        end
        default: state <= RIS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ris_sweep_sequencer.sv
// Directed, table-driven bench for ris_sweep_sequencer (DEPTH=4).
module tb_ris_sweep_sequencer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_clear = 1'b0;
  logic        sweep_start = 1'b0;
  logic [15:0] settle_cycles = '0;
  logic        snr_valid = 1'b0;
  logic [15:0] snr_data = '0;
  logic [31:0] cfg_word;
  logic        cfg_apply;
  logic        meas_req;
  logic        tx_start;
  logic [31:0] tx_data;
  logic        busy;
  logic [2:0]  entry_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] apq [$];
  logic [31:0] txq [$];

  typedef struct {
    int unsigned n;
    logic [31:0] w   [4];
    logic [15:0] snr [4];
    logic [15:0] settle;
    int unsigned best;
    logic [31:0] tx;
  } vec_t;

  vec_t vecs [5];

  ris_sweep_sequencer #(
    .DEPTH          (DEPTH),
    .SETTLE_W       (16),
    .SNR_W          (16),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_clear    (load_clear),
    .sweep_start   (sweep_start),
    .settle_cycles (settle_cycles),
    .snr_valid     (snr_valid),
    .snr_data      (snr_data),
    .cfg_word      (cfg_word),
    .cfg_apply     (cfg_apply),
    .meas_req      (meas_req),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .busy          (busy),
    .entry_count   (entry_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_apply) apq.push_back(cfg_word);
    if (tx_start)  txq.push_back(tx_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] w);
    load_valid = 1'b1;
    load_data  = w;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic clear_cb();
    load_clear = 1'b1;
    @(negedge clk);
    load_clear = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] s);
    settle_cycles = s;
    sweep_start   = 1'b1;
    @(negedge clk);
    sweep_start   = 1'b0;
  endtask

  task automatic answer(input logic [15:0] v, input string nm);
    int unsigned c = 0;
    while (!meas_req && c < 500) begin
      @(negedge clk);
      c++;
    end
    if (!meas_req) chk({nm, " meas_req wait"}, 32'(meas_req), 32'd1);
    snr_valid = 1'b1;
    snr_data  = v;
    @(negedge clk);
    snr_valid = 1'b0;
  endtask

  task automatic wait_tx(input string nm);
    int unsigned c = 0;
    while (txq.size() == 0 && c < 500) begin
      @(negedge clk);
      c++;
    end
    if (txq.size() == 0) chk({nm, " tx_start wait"}, 32'(txq.size()), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_idle_zero(input string nm);
    chk({nm, " cfg_word"},    cfg_word,           32'h0);
    chk({nm, " cfg_apply"},   32'(cfg_apply),     32'h0);
    chk({nm, " meas_req"},    32'(meas_req),      32'h0);
    chk({nm, " tx_start"},    32'(tx_start),      32'h0);
    chk({nm, " tx_data"},     tx_data,            32'h0);
    chk({nm, " busy"},        32'(busy),          32'h0);
    chk({nm, " entry_count"}, 32'(entry_count),   32'h0);
  endtask

  initial begin
    int unsigned c;
    int unsigned hits;

    vecs[0].n = 3; vecs[0].settle = 16'd4; vecs[0].best = 1; vecs[0].tx = 32'h0100_001E;
    vecs[0].w   = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0};
    vecs[0].snr = '{16'd10, 16'd30, 16'd20, 16'd0};
    vecs[1].n = 4; vecs[1].settle = 16'd2; vecs[1].best = 0; vecs[1].tx = 32'h0000_0019;
    vecs[1].w   = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C, 32'h0000_000D};
    vecs[1].snr = '{16'd25, 16'd25, 16'd25, 16'd25};
    vecs[2].n = 4; vecs[2].settle = 16'd0; vecs[2].best = 2; vecs[2].tx = 32'h0200_0028;
    vecs[2].w   = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};
    vecs[2].snr = '{16'd5, 16'd5, 16'd40, 16'd40};
    vecs[3].n = 2; vecs[3].settle = 16'd1; vecs[3].best = 0; vecs[3].tx = 32'h0000_0000;
    vecs[3].w   = '{32'hAAAA_5555, 32'h1234_5678, 32'h0, 32'h0};
    vecs[3].snr = '{16'd0, 16'd0, 16'd0, 16'd0};
    vecs[4].n = 4; vecs[4].settle = 16'd3; vecs[4].best = 3; vecs[4].tx = 32'h0300_FFFF;
    vecs[4].w   = '{32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004};
    vecs[4].snr = '{16'd1, 16'd2, 16'd3, 16'hFFFF};

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Table-driven sweeps
    for (int k = 0; k < 5; k++) begin
      clear_cb();
      for (int unsigned i = 0; i < vecs[k].n; i++) load_word(vecs[k].w[i]);
      chk($sformatf("v%0d entry_count", k), 32'(entry_count), vecs[k].n);
      apq.delete();
      txq.delete();
      pulse_start(vecs[k].settle);
      for (int unsigned i = 0; i < vecs[k].n; i++)
        answer(vecs[k].snr[i], $sformatf("v%0d e%0d", k, i));
      wait_tx($sformatf("v%0d", k));
      chk($sformatf("v%0d apply count", k), apq.size(), vecs[k].n + 1);
      if (apq.size() == vecs[k].n + 1) begin
        for (int unsigned i = 0; i < vecs[k].n; i++)
          chk($sformatf("v%0d apply %0d", k, i), apq[i], vecs[k].w[i]);
        chk($sformatf("v%0d best apply", k), apq[vecs[k].n], vecs[k].w[vecs[k].best]);
      end
      chk($sformatf("v%0d tx count", k), txq.size(), 1);
      if (txq.size() > 0) chk($sformatf("v%0d tx_data", k), txq[0], vecs[k].tx);
      chk($sformatf("v%0d busy after", k), 32'(busy), 32'h0);
    end

    // Cycle-exact latencies, settle=2, two entries
    clear_cb();
    load_word(32'h0000_0055);
    load_word(32'h0000_0066);
    txq.delete();
    settle_cycles = 16'd2;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    chk("lat apply not yet", 32'(cfg_apply), 32'h0);
    @(negedge clk);
    chk("lat apply pulse", 32'(cfg_apply), 32'h1);
    chk("lat cfg_word", cfg_word, 32'h0000_0055);
    c = 2;
    while (!meas_req && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("lat meas_req rise", c, 5);
    snr_valid = 1'b1;
    snr_data  = 16'd7;
    @(negedge clk);
    snr_valid = 1'b0;
    chk("lat meas_req fall", 32'(meas_req), 32'h0);
    c = 1;
    while (!cfg_apply && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("lat next apply", c, 3);
    chk("lat next word", cfg_word, 32'h0000_0066);
    answer(16'd3, "lat e1");
    c = 1;
    while (!tx_start && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("lat tx_start", c, 4);
    chk("lat tx_data", tx_data, 32'h0000_0007);
    chk("lat best word", cfg_word, 32'h0000_0055);
    repeat (2) @(negedge clk);

    // Load and start requests during a sweep are ignored
    clear_cb();
    for (int unsigned i = 0; i < 3; i++) load_word(32'h100 + i);
    txq.delete();
    apq.delete();
    pulse_start(16'd1);
    @(negedge clk);
    sweep_start = 1'b1;
    load_valid  = 1'b1;
    load_data   = 32'hBAD0_BAD0;
    @(negedge clk);
    sweep_start = 1'b0;
    load_valid  = 1'b0;
    chk("busy ignore entry_count", 32'(entry_count), 32'd3);
    for (int unsigned i = 0; i < 3; i++) answer(16'd25, "busy ignore");
    wait_tx("busy ignore");
    repeat (20) @(negedge clk);
    chk("busy ignore tx count", txq.size(), 1);
    if (txq.size() > 0) chk("busy ignore tx_data", txq[0], 32'h0000_0019);
    chk("busy ignore apply count", apq.size(), 4);
    chk("busy ignore entry_count after", 32'(entry_count), 32'd3);

    // Asynchronous reset in the middle of SETTLE
    clear_cb();
    load_word(32'h0000_0077);
    load_word(32'h0000_0088);
    pulse_start(16'd30);
    repeat (5) @(negedge clk);
    chk("pre-reset busy", 32'(busy), 32'h1);
    #2 reset = 1'b0;
    #1 check_idle_zero("mid reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    load_word(32'h0000_0099);
    load_word(32'h0000_00AA);
    apq.delete();
    txq.delete();
    pulse_start(16'd1);
    answer(16'd3, "post reset e0");
    answer(16'd9, "post reset e1");
    wait_tx("post reset");
    chk("post reset apply count", apq.size(), 3);
    if (apq.size() == 3) chk("post reset best apply", apq[2], 32'h0000_00AA);
    if (txq.size() > 0) chk("post reset tx_data", txq[0], 32'h0100_0009);

    // Sweep on an empty codebook
    clear_cb();
    apq.delete();
    txq.delete();
    pulse_start(16'd0);
    wait_tx("empty");
    chk("empty tx count", txq.size(), 1);
    if (txq.size() > 0) chk("empty tx_data", txq[0], 32'hFFFF_FFFF);
    chk("empty apply count", apq.size(), 0);
    chk("empty cfg_word kept", cfg_word, 32'h0000_00AA);

    // Overfill and clear-versus-load priority
    clear_cb();
    for (int unsigned i = 0; i < DEPTH + 1; i++) load_word(32'h101 + i);
    chk("full entry_count", 32'(entry_count), DEPTH);
    apq.delete();
    txq.delete();
    pulse_start(16'd0);
    answer(16'd4, "full e0");
    answer(16'd3, "full e1");
    answer(16'd2, "full e2");
    answer(16'd1, "full e3");
    wait_tx("full");
    hits = 0;
    foreach (apq[i]) if (apq[i] == 32'h105) hits++;
    chk("full extra word absent", hits, 0);
    chk("full apply count", apq.size(), 5);
    if (txq.size() > 0) chk("full tx_data", txq[0], 32'h0000_0004);
    load_clear = 1'b1;
    load_valid = 1'b1;
    load_data  = 32'h0000_0999;
    @(negedge clk);
    load_clear = 1'b0;
    load_valid = 1'b0;
    chk("clear wins entry_count", 32'(entry_count), 32'd0);

`ifdef RIS_SWEEP_TIMEOUT_EN
    // Entry 1 never answered: scored as zero after the timeout
    load_word(32'h0000_0E00);
    load_word(32'h0000_0E01);
    load_word(32'h0000_0E02);
    apq.delete();
    txq.delete();
    pulse_start(16'd0);
    answer(16'd5, "timeout e0");
    c = 0;
    while (!meas_req && c < 50) begin
      @(negedge clk);
      c++;
    end
    c = 0;
    while (meas_req && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("timeout length", c, 100);
    answer(16'd3, "timeout e2");
    wait_tx("timeout");
    if (txq.size() > 0) chk("timeout tx_data", txq[0], 32'h0000_0005);
    if (apq.size() == 4) chk("timeout best apply", apq[3], 32'h0000_0E00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ris_sweep_sequencer.md
# ris_sweep_sequencer

Codebook sweep controller for the RIS: stores up to DEPTH 32-bit phase-configuration words loaded from the RS232 receive path. On command it applies each word in turn to the GPIO decode stage, waits a programmable settle time, requests one SNR measurement per entry, and tracks the best entry. It finishes by re-applying the best configuration and handing a 32-bit result word to the UART transmitter.

## Interface
- DEPTH, 16: codebook entries (power of two, 2..256)
- SETTLE_W, 16: width of settle counter
- SNR_W, 16: SNR sample width, unsigned, ≤16
- TIMEOUT_CYCLES, 50000: measurement timeout (only with RIS_SWEEP_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, single domain
- reset  in  1  asynchronous, active-low reset
- load_valid  in  1  one-cycle pulse: write load_data at next free codebook slot
- load_data  in  32  configuration word, 2 bits per element, element 1 in [1:0]
- load_clear  in  1  one-cycle pulse: empty codebook
- sweep_start  in  1  one-cycle pulse: begin sweep
- settle_cycles  in  SETTLE_W  cycles to wait after each apply; sampled at sweep_start
- snr_valid  in  1  SNR sample present
- snr_data  in  SNR_W  SNR sample
- cfg_word  out  32  configuration currently driven to GPIO decode
- cfg_apply  out  1  one-cycle pulse when cfg_word updates
- meas_req  out  1  level, high while awaiting an SNR sample
- tx_start  out  1  one-cycle pulse, tx_data valid
- tx_data  out  32  result: [31:24] best index, [23:16] 0, [15:0] best SNR (zero-extended)
- busy  out  1  high in any state other than IDLE
- entry_count  out  $clog2(DEPTH)+1  valid codebook entries

## Operation
- FSM states: IDLE, APPLY, SETTLE, MEASURE, NEXT, BEST, REPORT.
- IDLE: loads and clears are accepted. load_valid with entry_count==DEPTH is ignored. load_clear and load_valid in the same cycle: clear wins, write dropped. Load/clear while busy is ignored.
- sweep_start in IDLE with entry_count>0 → APPLY, idx=0, best_snr=0, best_idx=0, settle_cycles latched. sweep_start while busy is ignored.
- sweep_start with entry_count==0 → REPORT directly. tx_data=32'hFFFF_FFFF; cfg_word is unchanged.
- APPLY: cfg_word←codebook[idx], cfg_apply=1 for one cycle → SETTLE.
- SETTLE: counts latched settle_cycles cycles (0 = no wait) → MEASURE.
- MEASURE: meas_req=1. snr_valid is sampled only here. On snr_valid: if snr_data > best_snr (strict), best_snr/best_idx update (ties keep the lower index) → NEXT.
- NEXT: if idx==entry_count-1 → BEST, else idx+1 → APPLY.
- BEST: cfg_word←codebook[best_idx], cfg_apply pulse → REPORT.
- REPORT: tx_start pulse with tx_data → IDLE.
- Reset (any time, including mid-sweep) asynchronously clears state to IDLE, all outputs to 0, entry_count to 0. Codebook contents need not be cleared.

## Timing
- sweep_start sampled at edge k → cfg_apply high and cfg_word valid after edge k+1.
- With settle S, meas_req rises after edge k+2+S.
- snr_valid sampled at edge m → meas_req low after m. The next cfg_apply occurs after edge m+2.
- The last sample at edge m → BEST cfg_apply after m+2 and tx_start after m+3.
- All outputs are registered. No combinational input→output path.

## Configuration
- RIS_SWEEP_TIMEOUT_EN defined: MEASURE carries a counter. If TIMEOUT_CYCLES elapse without snr_valid, the entry is scored as SNR 0 (never replaces best) and the FSM proceeds to NEXT.
- Undefined: MEASURE waits indefinitely and no counter is synthesised.

## Structure
- Shared package ris_pkg: FSM state enum, RIS_TX_EMPTY=32'hFFFF_FFFF, tx_data field positions, RIS_ELEM_BITS=2, RIS_ELEMS=16.
- Sub-module ris_codebook_ram: DEPTH×32 register file with one synchronous write port and one combinational read port. It is written only by load logic and read by the FSM.

## Test plan
- Load 3 words (0x0000_0001, 0x0000_0002, 0x0000_0003), settle=4, SNR replies 10, 30, 20 → cfg_apply sequence 1,2,3,2; tx_data=0x0100_001E.
- Sweep with entry_count=0 → one tx_start with 0xFFFF_FFFF, no cfg_apply.
- Load DEPTH+1 words → entry_count=DEPTH, extra word absent; load_clear with simultaneous load_valid → entry_count=0.
- Equal SNR 25 on all entries → best index 0; sweep_start and load_valid during sweep ignored.
- Reset low mid-SETTLE → all outputs 0 immediately; a new sweep after release runs normally.
- RIS_SWEEP_TIMEOUT_EN, TIMEOUT_CYCLES=100, no snr_valid for entry 1 → advance after 100 cycles; entry 1 never chosen.
